// File: rtl/cdr_pi_sweep_ctrl_pkg.sv
// cdr_pi_sweep_ctrl_pkg: shared PI/ADC widths and the eye-sweep FSM state encoding.
package cdr_pi_sweep_ctrl_pkg;
    localparam int Npi = 8;
    localparam int Nadc = 8;
    typedef enum logic [2:0] {IDLE, SETTLE, DWELL, EVAL, FINISH, HOLD} sweep_state_t;
endpackage

// File: rtl/cdr_err_window_cnt.sv
// cdr_err_window_cnt: counts checker errors over a dwell window with a saturating counter.
module cdr_err_window_cnt #(
    parameter int DWELL_W = 16,
    parameter int ERR_W = 16
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               clear,
    input  logic               enable,
    input  logic               err_pulse,
    input  logic [DWELL_W-1:0] dwell_len,
    output logic [ERR_W-1:0]   count,
    output logic               window_done
);
    logic [DWELL_W-1:0] cyc;
    logic [DWELL_W-1:0] last;
    // a zero dwell behaves as a one-cycle window
    assign last = (dwell_len == '0) ? '0 : dwell_len - DWELL_W'(1);
    assign window_done = enable && (cyc == last);
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cyc <= '0;
            count <= '0;
        end else if (clear) begin
            cyc <= '0;
            count <= '0;
        end else if (enable) begin
            cyc <= cyc + DWELL_W'(1);
            if (err_pulse && count != '1) count <= count + ERR_W'(1);
        end
    end
endmodule

// File: rtl/cdr_pi_sweep_ctrl.sv
// cdr_pi_sweep_ctrl: sweeps the external PI code, counts errors per code and parks the PI
// at the centre of the widest error-free window; otherwise passes JTAG debug values through.
module cdr_pi_sweep_ctrl
    import cdr_pi_sweep_ctrl_pkg::*;
#(
    parameter int DWELL_W = 16,
    parameter int ERR_W = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DWELL_W-1:0]     dwell_len,
    input  logic [ERR_W-1:0]       err_thresh,
    input  logic [Npi-1:0]         step,
    input  logic                   err_pulse,
    input  logic                   jtag_sel_ext_pi,
    input  logic [Npi-1:0]         jtag_pi_ctl_ext,
    input  logic                   jtag_sel_ext_pd_offset,
    input  logic signed [Nadc-1:0] jtag_pd_offset_ext,
    output logic                   sel_ext_pi,
    output logic [Npi-1:0]         pi_ctl_ext,
    output logic                   sel_ext_pd_offset,
    output logic signed [Nadc-1:0] pd_offset_ext,
    output logic                   busy,
    output logic                   done,
    output logic                   eye_valid,
    output logic [Npi-1:0]         eye_left,
    output logic [Npi-1:0]         eye_right,
    output logic [Npi-1:0]         eye_center
);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    sweep_state_t       state;
    logic [SW-1:0]      settle_cnt;
    logic [Npi-1:0]     code, step_q, cur_left, best_left, best_right, best_center, run_left;
    logic [Npi:0]       cur_len, best_len, run_len, nxt_sum;
    logic [DWELL_W-1:0] dwell_q;
    logic [ERR_W-1:0]   thr_q, err_cnt;
    logic               window_done, is_open;

    cdr_err_window_cnt #(.DWELL_W(DWELL_W), .ERR_W(ERR_W)) u_cnt (
        .clk        (clk),
        .rstb       (rstb),
        .clear      (state != DWELL),
        .enable     (state == DWELL),
        .err_pulse  (err_pulse),
        .dwell_len  (dwell_q),
        .count      (err_cnt),
        .window_done(window_done)
    );

    assign is_open = err_cnt <= thr_q;
    assign run_len = cur_len + (Npi+1)'(1);
    assign run_left = (cur_len == '0) ? code : cur_left;
    // carry bit of the next code marks the end of the PI range
    assign nxt_sum = {1'b0, code} + {1'b0, (step_q == '0) ? Npi'(1) : step_q};
    assign best_center = best_left + ((best_right - best_left) >> 1);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
            settle_cnt <= '0;
            code <= '0;
            step_q <= '0;
            dwell_q <= '0;
            thr_q <= '0;
            cur_len <= '0;
            cur_left <= '0;
            best_len <= '0;
            best_left <= '0;
            best_right <= '0;
            sel_ext_pi <= 1'b0;
            pi_ctl_ext <= '0;
            sel_ext_pd_offset <= 1'b0;
            pd_offset_ext <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            eye_valid <= 1'b0;
            eye_left <= '0;
            eye_right <= '0;
            eye_center <= '0;
        end else begin
            sel_ext_pi <= jtag_sel_ext_pi;
            pi_ctl_ext <= jtag_pi_ctl_ext;
            sel_ext_pd_offset <= jtag_sel_ext_pd_offset;
            pd_offset_ext <= jtag_pd_offset_ext;
            done <= 1'b0;
            if (abort && state != FINISH) begin
                state <= IDLE;
                busy <= 1'b0;
            end else if (start && (state == IDLE || state == HOLD)) begin
                state <= SETTLE;
                busy <= 1'b1;
                code <= '0;
                settle_cnt <= '0;
                dwell_q <= dwell_len;
                thr_q <= err_thresh;
                step_q <= step;
                cur_len <= '0;
                cur_left <= '0;
                best_len <= '0;
                best_left <= '0;
                best_right <= '0;
                sel_ext_pi <= 1'b1;
                pi_ctl_ext <= '0;
            end else begin
                case (state)
                    SETTLE: begin
                        sel_ext_pi <= 1'b1;
                        pi_ctl_ext <= code;
                        settle_cnt <= settle_cnt + SW'(1);
                        if (settle_cnt == SW'(SETTLE_CYC - 1)) state <= DWELL;
                    end
                    DWELL: begin
                        sel_ext_pi <= 1'b1;
                        pi_ctl_ext <= code;
                        if (window_done) state <= EVAL;
                    end
                    EVAL: begin
                        sel_ext_pi <= 1'b1;
                        cur_len <= is_open ? run_len : '0;
                        cur_left <= run_left;
                        // strictly longer only, so the first of tied runs is kept
                        if (is_open && run_len > best_len) begin
                            best_len <= run_len;
                            best_left <= run_left;
                            best_right <= code;
                        end
                        if (nxt_sum[Npi]) begin
                            state <= FINISH;
                            busy <= 1'b0;
                            pi_ctl_ext <= code;
                        end else begin
                            state <= SETTLE;
                            code <= nxt_sum[Npi-1:0];
                            settle_cnt <= '0;
                            pi_ctl_ext <= nxt_sum[Npi-1:0];
                        end
                    end
                    FINISH: begin
                        state <= HOLD;
                        done <= 1'b1;
                        eye_valid <= best_len != '0;
                        eye_left <= best_left;
                        eye_right <= best_right;
                        eye_center <= best_center;
                        if (best_len != '0) begin
                            sel_ext_pi <= 1'b1;
                            pi_ctl_ext <= best_center;
                        end
                    end
                    HOLD: begin
                        if (eye_valid) begin
                            sel_ext_pi <= 1'b1;
                            pi_ctl_ext <= eye_center;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cdr_pi_sweep_ctrl.sv
// tb_cdr_pi_sweep_ctrl: directed checks of passthrough, eye search, ties, abort and reset.
module tb_cdr_pi_sweep_ctrl;
    import cdr_pi_sweep_ctrl_pkg::*;

    logic clk = 1'b0, rstb = 1'b0, start = 1'b0, abort = 1'b0, err_pulse = 1'b0;
    logic [15:0] dwell_len = '0, err_thresh = '0;
    logic [Npi-1:0] step = '0, jtag_pi_ctl_ext = '0;
    logic jtag_sel_ext_pi = 1'b0, jtag_sel_ext_pd_offset = 1'b0;
    logic signed [Nadc-1:0] jtag_pd_offset_ext = '0;
    logic sel_ext_pi, sel_ext_pd_offset, busy, done, eye_valid;
    logic [Npi-1:0] pi_ctl_ext, eye_left, eye_right, eye_center;
    logic signed [Nadc-1:0] pd_offset_ext;
    int n_chk = 0, n_fail = 0, n_done = 0, err_mode = 0;

    cdr_pi_sweep_ctrl dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort),
        .dwell_len(dwell_len), .err_thresh(err_thresh), .step(step), .err_pulse(err_pulse),
        .jtag_sel_ext_pi(jtag_sel_ext_pi), .jtag_pi_ctl_ext(jtag_pi_ctl_ext),
        .jtag_sel_ext_pd_offset(jtag_sel_ext_pd_offset), .jtag_pd_offset_ext(jtag_pd_offset_ext),
        .sel_ext_pi(sel_ext_pi), .pi_ctl_ext(pi_ctl_ext),
        .sel_ext_pd_offset(sel_ext_pd_offset), .pd_offset_ext(pd_offset_ext),
        .busy(busy), .done(done), .eye_valid(eye_valid),
        .eye_left(eye_left), .eye_right(eye_right), .eye_center(eye_center)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) n_done++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance n cycles; err_pulse follows the PI code currently driven to the CDR
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            case (err_mode)
                1: err_pulse = (pi_ctl_ext < 48) || (pi_ctl_ext >= 160);
                2: err_pulse = !(pi_ctl_ext inside {8'd16, 8'd32, 8'd80, 8'd96});
                3: err_pulse = 1'b1;
                default: err_pulse = 1'b0;
            endcase
        end
    endtask

    task automatic pulse_start(input logic [15:0] d, input logic [15:0] t, input logic [Npi-1:0] s, input int mode);
        dwell_len = d;
        err_thresh = t;
        step = s;
        err_mode = mode;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input logic [15:0] d, input logic [15:0] t,
                             input logic [Npi-1:0] s, input int mode,
                             input logic v, input logic [Npi-1:0] l, input logic [Npi-1:0] r,
                             input logic [Npi-1:0] c, input logic hs, input logic [Npi-1:0] hc);
        int base = n_done;
        int k = 0;
        pulse_start(d, t, s, mode);
        check({tag, "_busy"}, busy, 1);
        while (!done && k < 20000) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_valid"}, eye_valid, v);
        check({tag, "_left"}, eye_left, l);
        check({tag, "_right"}, eye_right, r);
        check({tag, "_center"}, eye_center, c);
        check({tag, "_hold_sel"}, sel_ext_pi, hs);
        check({tag, "_hold_ctl"}, pi_ctl_ext, hc);
        tick(3);
        check({tag, "_one_done"}, n_done - base, 1);
        check({tag, "_hold_ctl_late"}, pi_ctl_ext, hc);
    endtask

    initial begin
        #2;
        check("rst_sel", sel_ext_pi, 0);
        check("rst_ctl", pi_ctl_ext, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", eye_valid, 0);
        check("rst_pd", pd_offset_ext, 0);
        #10 rstb = 1'b1;
        tick();

        jtag_sel_ext_pi = 1'b1;
        jtag_pi_ctl_ext = 8'd37;
        jtag_sel_ext_pd_offset = 1'b1;
        jtag_pd_offset_ext = -8'sd5;
        check("pt_before", pi_ctl_ext, 0);
        tick();
        check("pt_sel", sel_ext_pi, 1);
        check("pt_ctl", pi_ctl_ext, 37);
        check("pt_sel_pd", sel_ext_pd_offset, 1);
        check("pt_pd", pd_offset_ext, -5);

        run_sweep("basic", 16'd32, 16'd0, 8'd16, 1, 1'b1, 8'd48, 8'd144, 8'd96, 1'b1, 8'd96);
        run_sweep("tie_t3", 16'd3, 16'd3, 8'd16, 2, 1'b1, 8'd0, 8'd240, 8'd120, 1'b1, 8'd120);
        run_sweep("tie_t2", 16'd3, 16'd2, 8'd16, 2, 1'b1, 8'd16, 8'd32, 8'd24, 1'b1, 8'd24);

        begin : abort_test
            int base;
            base = n_done;
            jtag_sel_ext_pi = 1'b0;
            pulse_start(16'd4, 16'd0, 8'd16, 0);
            tick(35);
            check("abort_pre_busy", busy, 1);
            check("abort_pre_ctl", pi_ctl_ext, 32);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_sel", sel_ext_pi, 0);
            check("abort_ctl", pi_ctl_ext, 37);
            tick(60);
            check("abort_no_done", n_done - base, 0);
            check("abort_keep_left", eye_left, 16);
            check("abort_keep_valid", eye_valid, 1);
            check("abort_pd", pd_offset_ext, -5);
        end

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        tick(20);
        check("sa_busy_late", busy, 0);
        check("sa_ctl", pi_ctl_ext, 37);

        jtag_pi_ctl_ext = 8'd77;
        run_sweep("noeye", 16'd2, 16'd0, 8'd64, 3, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd77);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        pulse_start(16'd0, 16'd0, 8'd0, 0);
        tick(9);
        check("b_code0_end", pi_ctl_ext, 0);
        tick();
        check("b_code1", pi_ctl_ext, 1);
        tick(10);
        check("b_code2", pi_ctl_ext, 2);
        tick(9);
        check("b_code2_end", pi_ctl_ext, 2);
        tick();
        check("b_code3", pi_ctl_ext, 3);
        tick(3);
        #2 rstb = 1'b0;
        #1;
        check("arst_sel", sel_ext_pi, 0);
        check("arst_ctl", pi_ctl_ext, 0);
        check("arst_busy", busy, 0);
        check("arst_sel_pd", sel_ext_pd_offset, 0);
        check("arst_pd", pd_offset_ext, 0);
        check("arst_valid", eye_valid, 0);
        check("arst_center", eye_center, 0);
        #10 rstb = 1'b1;
        tick(2);
        check("arst_idle_ctl", pi_ctl_ext, 77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cdr_pi_sweep_ctrl.md
Name: cdr_pi_sweep_ctrl

Overview:
- Eye-scan sequencer for the CDR debug override path. It takes ownership of the external-PI controls, steps pi_ctl_ext across the PI range and counts checker errors at each code.
- It then finds the widest error-free window and parks the PI at that window's centre.
- When it is not sweeping, the JTAG-side debug values pass through to the CDR unchanged (registered, 1 cycle).
- Sits between the JTAG register file and the CDR end of cdr_debug_intf.

Parameters:
- DWELL_W, 16, width of the dwell-length input and dwell counter.
- ERR_W, 16, width of the error counter and threshold; the counter saturates.
- SETTLE_CYC, 8, idle cycles after each PI code change before counting starts (>=1).

Ports:
- clk  input  1  system clock.
- rstb  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a sweep from IDLE or HOLD.
- abort  input  1  single-cycle pulse; cancels a sweep or releases HOLD, returning to IDLE.
- dwell_len  input  DWELL_W  error-count window in cycles; 0 is treated as 1.
- err_thresh  input  ERR_W  a code is open if its count <= err_thresh.
- step  input  Npi  PI code increment; 0 is treated as 1.
- err_pulse  input  1  one error per asserted cycle, from the PRBS checker.
- jtag_sel_ext_pi  input  1  JTAG-requested override select.
- jtag_pi_ctl_ext  input  Npi  JTAG-requested PI code.
- jtag_sel_ext_pd_offset  input  1  JTAG pd-offset select.
- jtag_pd_offset_ext  input  signed Nadc  JTAG pd offset.
- sel_ext_pi  output  1  to cdr_debug_intf.
- pi_ctl_ext  output  Npi  to cdr_debug_intf.
- sel_ext_pd_offset  output  1  to cdr_debug_intf.
- pd_offset_ext  output  signed Nadc  to cdr_debug_intf.
- busy  output  1  high during a sweep.
- done  output  1  one-cycle pulse when a sweep completes.
- eye_valid  output  1  at least one open code was found.
- eye_left, eye_right, eye_center  output  Npi each  result codes.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- All outputs are registered.
- States:
  - IDLE: sel/ctl outputs equal the JTAG inputs delayed by 1 cycle. start -> SETTLE with code=0.
  - SETTLE: sel_ext_pi=1, pi_ctl_ext=code. Lasts SETTLE_CYC cycles, then -> DWELL.
  - DWELL: counts err_pulse for max(dwell_len,1) cycles; the counter saturates at 2^ERR_W-1. Then -> EVAL.
  - EVAL: one cycle.
    - Classify the code as open or closed.
    - Update the current run; record a new best run only if it is strictly longer than the previous best, so ties keep the first run found.
    - If code+max(step,1) > 2^Npi-1 (compute in Npi+1 bits; no wrap), -> FINISH. Otherwise set code += step and -> SETTLE.
  - FINISH: one cycle.
    - Close any run still open and latch eye_left/eye_right.
    - eye_center = eye_left + ((eye_right-eye_left)>>1), i.e. round toward left.
    - Set eye_valid; assert done and deassert busy. Then -> HOLD.
  - HOLD: sel_ext_pi=1 and pi_ctl_ext=eye_center if eye_valid. If not eye_valid, outputs revert to JTAG passthrough.
    - start -> new sweep; results stay until the next FINISH.
    - abort -> IDLE.
- Run bounds: a run is a set of consecutive visited codes, all open. eye_right is the last visited open code, not interpolated. If no code is open: eye_valid=0 and eye_left=eye_right=eye_center=0.
- busy: rises the cycle after start is accepted; high in SETTLE, DWELL and EVAL; low in FINISH.
- Cycle count per code: SETTLE_CYC + max(dwell_len,1) + 1.
- Input sampling: dwell_len, err_thresh and step are captured on start and held for the whole sweep.
- Start/abort rules:
  - start while busy is ignored.
  - abort while busy -> IDLE on the next edge; no done pulse, previous results kept; outputs return to passthrough.
  - start and abort in the same cycle: abort wins.
- pd-offset outputs are always a 1-cycle registered passthrough; the controller never alters them.
- Reset asserted mid-sweep: everything returns to reset values immediately.

Decomposition:
- Shared package (alongside Npi/Nadc in const_pack): sweep_state_t enum {IDLE, SETTLE, DWELL, EVAL, FINISH, HOLD}.
- One natural sub-module: cdr_err_window_cnt. It takes clear, enable, err_pulse and dwell_len, and returns a saturating count plus a window_done flag.
- The FSM, run tracking and output mux stay in the top module.

Test Plan:
- Passthrough: in IDLE set jtag_sel_ext_pi=1, jtag_pi_ctl_ext=37, jtag_pd_offset_ext=-5 -> the outputs show exactly these values 1 cycle later.
- Basic eye:
  - Stimulus: step=16, dwell_len=32, err_thresh=0. Drive err_pulse every cycle while pi_ctl_ext<48 or >=160; none otherwise.
  - Required response: eye_left=48, eye_right=144, eye_center=96, eye_valid=1, a single done pulse.
  - After done, pi_ctl_ext=96 and sel_ext_pi=1.
- Tie and threshold:
  - Stimulus: open windows 16..32 and 80..96 (step=16), 3 errors per closed code, err_thresh=3.
  - Required response: every code is open, eye_left=0, eye_right=last visited code.
  - Repeat with err_thresh=2: result is 16..32 (the first of the tied runs).
- No eye: err_pulse held high throughout -> eye_valid=0, all eye_* = 0; HOLD outputs show JTAG passthrough values.
- Abort:
  - Abort in the 3rd DWELL -> busy=0 next cycle, no done pulse, outputs revert to passthrough.
  - start and abort in the same cycle while in IDLE -> remains IDLE.
- Boundaries:
  - step=0 and dwell_len=0 -> each code lasts SETTLE_CYC+2 cycles and codes advance by 1.
  - Async rstb pulse mid-SETTLE -> all outputs are 0 immediately.
